// File: rtl/btn_evt_pkg.sv
// Shared types for the push-button event scheduler: event kinds, per-button FSM states
// and the round-robin index wrap helper.
package btn_evt_pkg;

  typedef enum logic [1:0] {
    EVT_PRESS   = 2'd0,
    EVT_LONG    = 2'd1,
    EVT_REPEAT  = 2'd2,
    EVT_RELEASE = 2'd3
  } evt_kind_t;

  typedef enum logic [1:0] {
    B_IDLE = 2'd0,
    B_HELD = 2'd1,
    B_REP  = 2'd2
  } btn_fsm_t;

  // Wrap a round-robin candidate index that may run at most one lap past n-1.
  function automatic int rr_wrap(input int v, input int n);
    return (v >= n) ? (v - n) : v;
  endfunction

endpackage

// File: rtl/btn_press_timer.sv
// One button's press/long/repeat/release classifier; the raise output is combinational so the
// owning slot loads on the same edge as the FSM moves. No backpressure: events are always raised.
module btn_press_timer
  import btn_evt_pkg::*;
#(
  parameter int          CNT_W      = 27,
  parameter int unsigned LONG_CYC   = 100_000_000,
  parameter int unsigned REPEAT_CYC = 20_000_000
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      btn_state,
  input  logic      btn_posedge,
  input  logic      btn_negedge,
  output logic      raise_vld,
  output evt_kind_t raise_kind
);

  localparam logic [CNT_W-1:0] LONG_TC = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] REP_TC  = CNT_W'(REPEAT_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  btn_fsm_t         state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             release_hit;

  // A lost negedge is recovered from the level so the FSM cannot stick in a held state.
  assign release_hit = btn_negedge || !btn_state;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    raise_vld  = 1'b0;
    raise_kind = EVT_PRESS;
    case (state_q)
      B_IDLE: begin
        if (btn_posedge) begin
          state_d   = B_HELD;
          cnt_d     = '0;
          raise_vld = 1'b1;
        end
      end
      B_HELD: begin
        if (release_hit) begin
          state_d    = B_IDLE;
          cnt_d      = '0;
          raise_vld  = 1'b1;
          raise_kind = EVT_RELEASE;
        end else if (cnt_q == LONG_TC) begin
          state_d    = B_REP;
          cnt_d      = '0;
          raise_vld  = 1'b1;
          raise_kind = EVT_LONG;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      B_REP: begin
        if (release_hit) begin
          state_d    = B_IDLE;
          cnt_d      = '0;
          raise_vld  = 1'b1;
          raise_kind = EVT_RELEASE;
        end else if (cnt_q == REP_TC) begin
          cnt_d      = '0;
          raise_vld  = 1'b1;
          raise_kind = EVT_REPEAT;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = B_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= B_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/btn_event_scheduler.sv
// Per-button event slots serialized by a round-robin arbiter into one registered valid/ready
// stream; press-to-evt_valid is 2 cycles, and a stalled consumer holds the output while slots overwrite.
module btn_event_scheduler
  import btn_evt_pkg::*;
#(
  parameter int          NUM_BTN    = 4,
  parameter int          ID_W       = $clog2(NUM_BTN),
  parameter int          CNT_W      = 27,
  parameter int unsigned LONG_CYC   = 100_000_000,
  parameter int unsigned REPEAT_CYC = 20_000_000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_BTN-1:0] btn_state,
  input  logic [NUM_BTN-1:0] btn_posedge,
  input  logic [NUM_BTN-1:0] btn_negedge,
  output logic               evt_valid,
  input  logic               evt_ready,
  output logic [ID_W-1:0]    evt_id,
  output logic [1:0]         evt_kind,
  output logic [NUM_BTN-1:0] pending,
  output logic               overflow
);

  logic [NUM_BTN-1:0] raise_vld;
  evt_kind_t          raise_kind [NUM_BTN];

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    btn_press_timer #(
      .CNT_W      (CNT_W),
      .LONG_CYC   (LONG_CYC),
      .REPEAT_CYC (REPEAT_CYC)
    ) u_timer (
      .clk         (clk),
      .rst         (rst),
      .btn_state   (btn_state[g]),
      .btn_posedge (btn_posedge[g]),
      .btn_negedge (btn_negedge[g]),
      .raise_vld   (raise_vld[g]),
      .raise_kind  (raise_kind[g])
    );
  end

  logic [NUM_BTN-1:0] pend_vld_q, pend_vld_d;
  evt_kind_t          pend_kind_q [NUM_BTN];
  evt_kind_t          pend_kind_d [NUM_BTN];
  logic               evt_valid_q, evt_valid_d;
  logic [ID_W-1:0]    evt_id_q, evt_id_d;
  evt_kind_t          evt_kind_q, evt_kind_d;
  logic [ID_W-1:0]    last_grant_q, last_grant_d;
  logic               overflow_q, overflow_d;

  logic               out_load;
  logic               gnt_found;
  logic [ID_W-1:0]    gnt_idx;

  assign out_load = !evt_valid_q || evt_ready;

  // First pending slot at or after last_grant+1, wrapping once around.
  always_comb begin
    gnt_found = 1'b0;
    gnt_idx   = '0;
    for (int k = 1; k <= NUM_BTN; k++) begin
      automatic logic [ID_W-1:0] cand = ID_W'(rr_wrap(int'(last_grant_q) + k, NUM_BTN));
      if (!gnt_found && pend_vld_q[cand]) begin
        gnt_found = 1'b1;
        gnt_idx   = cand;
      end
    end
  end

  always_comb begin
    evt_valid_d  = evt_valid_q;
    evt_id_d     = evt_id_q;
    evt_kind_d   = evt_kind_q;
    last_grant_d = last_grant_q;
    overflow_d   = 1'b0;
    if (out_load) begin
      evt_valid_d = gnt_found;
      if (gnt_found) begin
        evt_id_d     = gnt_idx;
        evt_kind_d   = pend_kind_q[gnt_idx];
        last_grant_d = gnt_idx;
      end
    end
    for (int i = 0; i < NUM_BTN; i++) begin
      automatic logic granted = out_load && gnt_found && (gnt_idx == ID_W'(i));
      pend_vld_d[i]  = pend_vld_q[i] && !granted;
      pend_kind_d[i] = pend_kind_q[i];
      // A new event always wins the slot; it only counts as lost data if the old one stays put.
      if (raise_vld[i]) begin
        pend_vld_d[i]  = 1'b1;
        pend_kind_d[i] = raise_kind[i];
        if (pend_vld_q[i] && !granted) overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_vld_q   <= '0;
      evt_valid_q  <= 1'b0;
      evt_id_q     <= '0;
      evt_kind_q   <= EVT_PRESS;
      last_grant_q <= ID_W'(NUM_BTN - 1);
      overflow_q   <= 1'b0;
      for (int i = 0; i < NUM_BTN; i++) pend_kind_q[i] <= EVT_PRESS;
    end else begin
      pend_vld_q   <= pend_vld_d;
      evt_valid_q  <= evt_valid_d;
      evt_id_q     <= evt_id_d;
      evt_kind_q   <= evt_kind_d;
      last_grant_q <= last_grant_d;
      overflow_q   <= overflow_d;
      for (int i = 0; i < NUM_BTN; i++) pend_kind_q[i] <= pend_kind_d[i];
    end
  end

  assign evt_valid = evt_valid_q;
  assign evt_id    = evt_id_q;
  assign evt_kind  = evt_kind_q;
  assign pending   = pend_vld_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_btn_event_scheduler.sv
// Directed bench for btn_event_scheduler with NUM_BTN=4, LONG_CYC=8, REPEAT_CYC=4.
module tb_btn_event_scheduler;

  localparam int NB = 4;
  localparam logic [31:0] K_PRESS = 32'd0;
  localparam logic [31:0] K_LONG  = 32'd1;
  localparam logic [31:0] K_REP   = 32'd2;
  localparam logic [31:0] K_REL   = 32'd3;

  logic          clk;
  logic          rst;
  logic [NB-1:0] btn_state;
  logic [NB-1:0] btn_posedge;
  logic [NB-1:0] btn_negedge;
  logic          evt_valid;
  logic          evt_ready;
  logic [1:0]    evt_id;
  logic [1:0]    evt_kind;
  logic [NB-1:0] pending;
  logic          overflow;

  btn_event_scheduler #(
    .NUM_BTN    (NB),
    .ID_W       (2),
    .CNT_W      (8),
    .LONG_CYC   (8),
    .REPEAT_CYC (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .btn_state   (btn_state),
    .btn_posedge (btn_posedge),
    .btn_negedge (btn_negedge),
    .evt_valid   (evt_valid),
    .evt_ready   (evt_ready),
    .evt_id      (evt_id),
    .evt_kind    (evt_kind),
    .pending     (pending),
    .overflow    (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks  = 0;
  int errors  = 0;
  int cyc     = 0;
  int ovf_cnt = 0;
  int ovf0    = 0;

  logic [31:0] got_cyc[$], got_id[$], got_kind[$];
  logic [31:0] exp_cyc[$], exp_id[$], exp_kind[$];

  always @(negedge clk) if (!rst && overflow === 1'b1) ovf_cnt++;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Logs a transfer of the current cycle, then advances to 1 time unit past the next edge.
  task automatic step();
    if (evt_valid === 1'b1 && evt_ready === 1'b1) begin
      got_cyc.push_back(32'(cyc));
      got_id.push_back(32'(evt_id));
      got_kind.push_back(32'(evt_kind));
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic new_test();
    got_cyc.delete(); got_id.delete(); got_kind.delete();
    exp_cyc.delete(); exp_id.delete(); exp_kind.delete();
    cyc  = 0;
    ovf0 = ovf_cnt;
  endtask

  task automatic expect_evt(input int c, input int id, input logic [31:0] k);
    exp_cyc.push_back(32'(c));
    exp_id.push_back(32'(id));
    exp_kind.push_back(k);
  endtask

  task automatic cmp_events(input string tag);
    int n;
    chk($sformatf("%s count", tag), 32'(got_cyc.size()), 32'(exp_cyc.size()));
    n = (got_cyc.size() < exp_cyc.size()) ? got_cyc.size() : exp_cyc.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s[%0d] cycle", tag, i), got_cyc[i], exp_cyc[i]);
      chk($sformatf("%s[%0d] id", tag, i), got_id[i], exp_id[i]);
      chk($sformatf("%s[%0d] kind", tag, i), got_kind[i], exp_kind[i]);
    end
  endtask

  initial begin
    rst         = 1'b1;
    btn_state   = '0;
    btn_posedge = '0;
    btn_negedge = '0;
    evt_ready   = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset evt_valid", 32'(evt_valid), 32'd0);
    chk("reset evt_id", 32'(evt_id), 32'd0);
    chk("reset evt_kind", 32'(evt_kind), 32'd0);
    chk("reset pending", 32'(pending), 32'd0);
    chk("reset overflow", 32'(overflow), 32'd0);
    rst = 1'b0;
    step();
    step();

    // Simultaneous press then release on all buttons, starting from reset priority.
    new_test();
    btn_state   = 4'hF;
    btn_posedge = 4'hF;
    step();
    btn_posedge = '0;
    chk("simul pending", 32'(pending), 32'hF);
    while (cyc < 6) step();
    btn_state   = '0;
    btn_negedge = 4'hF;
    step();
    btn_negedge = '0;
    while (cyc < 13) step();
    for (int i = 0; i < NB; i++) expect_evt(2 + i, i, K_PRESS);
    for (int i = 0; i < NB; i++) expect_evt(8 + i, i, K_REL);
    cmp_events("simul");
    chk("simul overflow", 32'(ovf_cnt - ovf0), 32'd0);

    // Short press on button 1.
    new_test();
    btn_state[1]   = 1'b1;
    btn_posedge[1] = 1'b1;
    step();
    btn_posedge[1] = 1'b0;
    while (cyc < 3) step();
    btn_state[1]   = 1'b0;
    btn_negedge[1] = 1'b1;
    step();
    btn_negedge[1] = 1'b0;
    while (cyc < 7) step();
    expect_evt(2, 1, K_PRESS);
    expect_evt(5, 1, K_REL);
    cmp_events("short");
    chk("short overflow", 32'(ovf_cnt - ovf0), 32'd0);

    // Long hold on button 2: release lands on the same cycle as a third REPEAT terminal count.
    new_test();
    btn_state[2]   = 1'b1;
    btn_posedge[2] = 1'b1;
    step();
    btn_posedge[2] = 1'b0;
    while (cyc < 20) step();
    btn_state[2]   = 1'b0;
    btn_negedge[2] = 1'b1;
    step();
    btn_negedge[2] = 1'b0;
    while (cyc < 26) step();
    expect_evt(2, 2, K_PRESS);
    expect_evt(10, 2, K_LONG);
    expect_evt(14, 2, K_REP);
    expect_evt(18, 2, K_REP);
    expect_evt(22, 2, K_REL);
    cmp_events("long");

    // Level drops without a negedge pulse while held.
    new_test();
    btn_state[0]   = 1'b1;
    btn_posedge[0] = 1'b1;
    step();
    btn_posedge[0] = 1'b0;
    while (cyc < 3) step();
    btn_state[0] = 1'b0;
    while (cyc < 16) step();
    expect_evt(2, 0, K_PRESS);
    expect_evt(5, 0, K_REL);
    cmp_events("lost_edge");

    // Backpressure on button 0 with a slot overwrite.
    new_test();
    btn_state[0]   = 1'b1;
    btn_posedge[0] = 1'b1;
    step();
    btn_posedge[0] = 1'b0;
    step();
    evt_ready = 1'b0;
    chk("bp valid c2", 32'(evt_valid), 32'd1);
    chk("bp kind c2", 32'(evt_kind), K_PRESS);
    btn_state[0]   = 1'b0;
    btn_negedge[0] = 1'b1;
    step();
    btn_negedge[0] = 1'b0;
    chk("bp pending c3", 32'(pending), 32'h1);
    step();
    btn_state[0]   = 1'b1;
    btn_posedge[0] = 1'b1;
    step();
    btn_posedge[0] = 1'b0;
    chk("bp overflow c5", 32'(overflow), 32'd1);
    while (cyc < 10) step();
    chk("bp valid c10", 32'(evt_valid), 32'd1);
    chk("bp id c10", 32'(evt_id), 32'd0);
    chk("bp kind c10", 32'(evt_kind), K_PRESS);
    chk("bp overflow c10", 32'(overflow), 32'd0);
    evt_ready = 1'b1;
    step();
    btn_state[0]   = 1'b0;
    btn_negedge[0] = 1'b1;
    step();
    btn_negedge[0] = 1'b0;
    while (cyc < 15) step();
    expect_evt(10, 0, K_PRESS);
    expect_evt(11, 0, K_PRESS);
    expect_evt(13, 0, K_REL);
    cmp_events("backpressure");
    chk("bp overflow pulses", 32'(ovf_cnt - ovf0), 32'd1);

    // Async reset with a held LONG on the output and button 3 in B_REP.
    new_test();
    btn_state[3]   = 1'b1;
    btn_posedge[3] = 1'b1;
    step();
    btn_posedge[3] = 1'b0;
    while (cyc < 10) step();
    evt_ready = 1'b0;
    while (cyc < 12) step();
    chk("pre-rst valid", 32'(evt_valid), 32'd1);
    chk("pre-rst id", 32'(evt_id), 32'd3);
    chk("pre-rst kind", 32'(evt_kind), K_LONG);
    expect_evt(2, 3, K_PRESS);
    cmp_events("pre_rst");
    #2;
    rst = 1'b1;
    #1;
    chk("rst valid", 32'(evt_valid), 32'd0);
    chk("rst id", 32'(evt_id), 32'd0);
    chk("rst kind", 32'(evt_kind), 32'd0);
    chk("rst pending", 32'(pending), 32'd0);
    chk("rst overflow", 32'(overflow), 32'd0);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    evt_ready = 1'b1;
    new_test();
    while (cyc < 20) step();
    cmp_events("post_rst_quiet");
    new_test();
    btn_posedge[3] = 1'b1;
    step();
    btn_posedge[3] = 1'b0;
    while (cyc < 4) step();
    expect_evt(2, 3, K_PRESS);
    cmp_events("post_rst_press");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/btn_event_scheduler.md
# btn_event_scheduler

Collects edge pulses and levels from several debounced push-buttons and classifies each button's activity into PRESS, LONG, REPEAT and RELEASE events. It then serializes all buttons onto one valid/ready event stream using round-robin arbitration. It sits directly after the bank of per-button debouncers and feeds the menu/control FSM, so downstream logic sees one ordered event per cycle instead of N raw lines.

## Interface
- NUM_BTN, 4, number of buttons (2..16)
- ID_W, $clog2(NUM_BTN), event id width
- CNT_W, 27, hold-counter width
- LONG_CYC, 100_000_000, cycles of continuous hold before LONG (1 s @ 100 MHz)
- REPEAT_CYC, 20_000_000, cycles between REPEAT events after LONG
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- btn_state  in  NUM_BTN  debounced level per button
- btn_posedge  in  NUM_BTN  1-cycle pulse, debounced press
- btn_negedge  in  NUM_BTN  1-cycle pulse, debounced release
- evt_valid  out  1  output event available
- evt_ready  in  1  consumer accepts when high with evt_valid
- evt_id  out  ID_W  button index of event
- evt_kind  out  2  0=PRESS, 1=LONG, 2=REPEAT, 3=RELEASE
- pending  out  NUM_BTN  per-button slot occupied
- overflow  out  1  1-cycle pulse: pending event overwritten

## Operation
- Per-button FSM with states B_IDLE, B_HELD, B_REP, and a CNT_W-bit counter.
  - B_IDLE: on btn_posedge, go to B_HELD, clear counter, raise PRESS.
  - B_HELD: counter increments each cycle. At count == LONG_CYC-1, go to B_REP, clear counter, raise LONG.
  - B_REP: counter increments. At count == REPEAT_CYC-1, clear counter and raise REPEAT; stay in B_REP.
  - B_HELD/B_REP: btn_negedge, or btn_state==0 (lost-edge recovery), goes to B_IDLE and raises RELEASE. Release wins over a same-cycle LONG/REPEAT terminal count.
  - btn_posedge outside B_IDLE is ignored.
- Each button has a one-deep pending slot holding {kind}.
  - A raised event loads the slot.
  - If the slot is already full and not being granted that cycle, the new event overwrites it and overflow pulses.
  - If the slot is granted in the same cycle a new event arrives, the new event loads and there is no overflow.
- Round-robin arbiter over pending slots with output register {evt_valid, evt_id, evt_kind}.
  - The output loads when evt_valid==0 or (evt_valid && evt_ready).
  - Search starts at last_grant+1 mod NUM_BTN; the granted slot clears on load.
  - If no slot is pending at load time, evt_valid drops to 0.
- Handshake rules: evt_id/evt_kind are stable while evt_valid && !evt_ready. evt_valid never drops without acceptance.
- Reset values: all FSMs B_IDLE, counters 0, pending 0, evt_valid 0, evt_id 0, evt_kind 0, overflow 0, last_grant NUM_BTN-1 (button 0 has first priority).

## Timing
- Edge pulse at cycle T: FSM and slot update at edge T+1; evt_valid high at T+2 if the output register is free.
- LONG: the slot loads LONG_CYC cycles after the PRESS slot load. REPEAT follows every REPEAT_CYC cycles.
- Throughput: one event per cycle with evt_ready held high (back-to-back reload on the accept edge).
- Counter never wraps: it clears at each terminal count; CNT_W must cover max(LONG_CYC, REPEAT_CYC).
- Asynchronous reset mid-transfer drops any in-flight event; there is no partial state after release of reset.

## Structure
- Package btn_evt_pkg:
  - evt_kind_t enum (EVT_PRESS, EVT_LONG, EVT_REPEAT, EVT_RELEASE)
  - btn_fsm_t enum (B_IDLE, B_HELD, B_REP)
- Sub-module btn_press_timer: one button's FSM, counter and event-raise output (valid + kind). Instantiated NUM_BTN times by generate.
- The top level holds the pending slots, round-robin arbiter and output register.

## Test plan
All cases use NUM_BTN=4, LONG_CYC=8, REPEAT_CYC=4, evt_ready=1 unless noted.
- Short press: posedge btn1 at cycle 10, negedge at cycle 13 -> evt (id1, PRESS) at cycle 12, then (id1, RELEASE) at cycle 15; overflow 0.
- Long hold: btn2 pressed at cycle 10 and held 20 cycles -> PRESS, then LONG 8 cycles after PRESS, then REPEAT every 4 cycles, then RELEASE. Sequence must be PRESS, LONG, REPEAT, REPEAT, RELEASE.
- Simultaneous press: posedge on btn0..3 in the same cycle -> ids 0,1,2,3 on consecutive cycles. A second simultaneous burst is served starting at id 0 after last_grant=3.
- Backpressure: evt_ready=0 for 10 cycles with btn0 press+release -> first PRESS held stable with evt_valid=1. Slot0 holds RELEASE; after a further repeat press, overflow pulses once, and the newest event is delivered when ready returns.
- Async reset asserted while evt_valid=1 and btn3 in B_REP -> all outputs 0 immediately. After deassert, no event appears until a new posedge.
- btn_state falls to 0 without a negedge pulse while in B_HELD -> exactly one RELEASE, FSM returns to B_IDLE.
